// File: rtl/nubus_pkg.sv
// Shared types and helpers for the NuBus block master: status codes, FSM
// encodings, TM line codes and the block-size address encoder.
package nubus_pkg;

   typedef enum logic [1:0] {
      ST_OK    = 2'd0,
      ST_ERR   = 2'd1,
      ST_TMO   = 2'd2,
      ST_RETRY = 2'd3
   } status_e;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_ARB  = 3'd1;
   localparam logic [2:0] S_ADDR = 3'd2;
   localparam logic [2:0] S_DATA = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [1:0] TM_OK    = 2'b00;
   localparam logic [1:0] TM_ERR   = 2'b01;
   localparam logic [1:0] TM_TMO   = 2'b10;
   localparam logic [1:0] TM_RETRY = 2'b11;

   // Block transfers replace the low word-address bits with a one-hot size code.
   function automatic logic [31:0] blk_addr_encode(input logic [31:0] addr,
                                                   input logic [2:0]  len);
      logic [3:0] sz;
      sz = 4'b0001 << (len - 3'd1);
      if (len == 3'd0) return {addr[31:2], 2'b00};
      return {addr[31:6], sz, 2'b00};
   endfunction

endpackage

// File: rtl/nubus_block_master_if.sv
// Requester-side and bus-side signal bundle of the NuBus block master.
interface nubus_block_master_if;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr;
   logic [2:0]  req_len;
   logic [31:0] wdata, rdata;
   logic        wdata_valid, wdata_ready, rdata_valid;
   logic        done;
   logic [1:0]  status;
   logic [4:0]  beats;
   logic        arb_grant, arbcy_o, rqst_o;
   logic        start_i, ack_i, tm1_i, tm0_i;
   logic        start_o, ack_o, tm1_o, tm0_o, tm_oe;
   logic [31:0] ad_i, ad_o;
   logic        ad_oe;

   modport master (
      input  req_valid, req_addr, req_write, req_len, wdata, wdata_valid,
             arb_grant, start_i, ack_i, tm1_i, tm0_i, ad_i,
      output req_ready, wdata_ready, rdata, rdata_valid, done, status, beats,
             arbcy_o, rqst_o, start_o, ack_o, tm1_o, tm0_o, tm_oe, ad_o, ad_oe
   );

   modport slave (
      output req_valid, req_addr, req_write, req_len, wdata, wdata_valid,
             arb_grant, start_i, ack_i, tm1_i, tm0_i, ad_i,
      input  req_ready, wdata_ready, rdata, rdata_valid, done, status, beats,
             arbcy_o, rqst_o, start_o, ack_o, tm1_o, tm0_o, tm_oe, ad_o, ad_oe
   );
endinterface

// File: rtl/nubus_block_wdt.sv
// Per-beat watchdog: counts enabled cycles from a clear and saturates at
// all-ones, which is the terminal count.
module nubus_block_wdt #(
   parameter int WDT_W = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   logic [WDT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst || clr)     cnt <= '0;
      else if (en && !tc) cnt <= cnt + 1'b1;
   end

   assign tc = &cnt;
endmodule

// File: rtl/nubus_block_master.sv
// NuBus master transfer engine: block reads/writes of 1..2^MAX_BLOCK_LOG2
// words with try-again retry, per-beat watchdog and streamed beat data.
module nubus_block_master
   import nubus_pkg::*;
#(
   parameter int MAX_BLOCK_LOG2 = 4,
   parameter int WDT_W          = 8,
   parameter int RETRY_MAX      = 3
) (
   input  logic                 nub_clk,
   input  logic                 nub_reset,
   nubus_block_master_if.master bus
);
   logic [2:0]  state_q;
   logic [31:0] addr_q, wd_hold_q, align_mask;
   logic        write_q, busy_q, underrun_q;
   logic [2:0]  len_q;
   logic [4:0]  beat_q, last_idx;
   logic [7:0]  retry_q;
   status_e     stat_q;
   logic [1:0]  code;
   logic        req_bad, accept, in_data, inter, fin_ok, strobe, wdt_tc, und_now;

   always_comb begin
      align_mask = ((32'd1 << ({2'b00, bus.req_len} + 5'd2)) - 32'd1) & ~32'd3;
      req_bad    = (bus.req_len > 3'(MAX_BLOCK_LOG2)) || ((bus.req_addr & align_mask) != '0);
      accept     = bus.req_valid && bus.req_ready;
      in_data    = (state_q == S_DATA);
      code       = {bus.tm1_i, bus.tm0_i};
      last_idx   = (5'd1 << len_q) - 5'd1;
      inter      = in_data && !bus.ack_i && bus.tm0_i && (beat_q != last_idx);
      fin_ok     = in_data && bus.ack_i && (code == TM_OK);
      strobe     = inter || fin_ok;
      // A write beat taken while the requester has nothing ready poisons the transfer.
      und_now    = underrun_q || (write_q && strobe && !bus.wdata_valid);
   end

   nubus_block_wdt #(.WDT_W(WDT_W)) u_wdt (
      .clk (nub_clk),
      .rst (nub_reset),
      .clr (!in_data || strobe),
      .en  (in_data),
      .tc  (wdt_tc)
   );

   always_ff @(posedge nub_clk) begin
      if (nub_reset)          busy_q <= 1'b0;
      else if (bus.start_i)   busy_q <= 1'b1;
      else if (bus.ack_i)     busy_q <= 1'b0;
   end

   always_ff @(posedge nub_clk) begin
      if (nub_reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         write_q    <= 1'b0;
         len_q      <= '0;
         beat_q     <= '0;
         retry_q    <= '0;
         stat_q     <= ST_OK;
         underrun_q <= 1'b0;
         wd_hold_q  <= '0;
      end else begin
         if (bus.wdata_valid) wd_hold_q <= bus.wdata;
         case (state_q)
            S_IDLE: if (accept) begin
               addr_q     <= bus.req_addr;
               write_q    <= bus.req_write;
               len_q      <= bus.req_len;
               beat_q     <= '0;
               underrun_q <= 1'b0;
               stat_q     <= ST_ERR;
               state_q    <= req_bad ? S_DONE : S_ARB;
            end
            S_ARB:  if (bus.arb_grant && !busy_q && !bus.start_i) state_q <= S_ADDR;
            S_ADDR: state_q <= S_DATA;
            S_DATA: begin
               if (strobe) beat_q <= beat_q + 5'd1;
               underrun_q <= und_now;
               if (bus.ack_i) begin
                  if (code == TM_RETRY && retry_q < 8'(RETRY_MAX)) begin
                     retry_q    <= retry_q + 8'd1;
                     beat_q     <= '0;
                     underrun_q <= 1'b0;
                     state_q    <= S_ARB;
                  end else begin
                     // Bus codes map one-to-one onto status, including exhausted retry.
                     stat_q  <= und_now ? ST_ERR : status_e'(code);
                     state_q <= S_DONE;
                  end
               end else if (wdt_tc) begin
                  stat_q  <= und_now ? ST_ERR : ST_TMO;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               retry_q <= '0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.req_ready   = (state_q == S_IDLE) && !nub_reset;
      bus.wdata_ready = 1'b0;
      bus.rdata       = '0;
      bus.rdata_valid = 1'b0;
      bus.done        = 1'b0;
      bus.status      = 2'b00;
      bus.beats       = '0;
      bus.arbcy_o     = 1'b0;
      bus.rqst_o      = 1'b0;
      bus.start_o     = 1'b0;
      bus.ack_o       = 1'b0;
      bus.tm1_o       = 1'b0;
      bus.tm0_o       = 1'b0;
      bus.tm_oe       = 1'b0;
      bus.ad_o        = '0;
      bus.ad_oe       = 1'b0;
      case (state_q)
         S_ARB: begin
            bus.rqst_o  = 1'b1;
            bus.arbcy_o = 1'b1;
         end
         S_ADDR: begin
            bus.rqst_o  = 1'b1;
            bus.start_o = 1'b1;
            bus.ad_oe   = 1'b1;
            bus.tm_oe   = 1'b1;
            bus.tm1_o   = write_q;
            bus.tm0_o   = (len_q != 3'd0);
            bus.ad_o    = blk_addr_encode(addr_q, len_q);
         end
         S_DATA: begin
            bus.ad_oe       = write_q;
            bus.ad_o        = !write_q ? '0 : (bus.wdata_valid ? bus.wdata : wd_hold_q);
            bus.ack_o       = !bus.ack_i && wdt_tc;
            bus.wdata_ready = write_q && strobe;
            bus.rdata_valid = !write_q && strobe;
            bus.rdata       = (!write_q && strobe) ? bus.ad_i : '0;
         end
         S_DONE: begin
            bus.done   = 1'b1;
            bus.status = stat_q;
            bus.beats  = beat_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_nubus_block_master.sv
// Directed bench for nubus_block_master with a scripted NuBus slave.
module tb_nubus_block_master;
   logic nub_clk, nub_reset;
   int   errors = 0, checks = 0;

   nubus_block_master_if bus();

   nubus_block_master #(.MAX_BLOCK_LOG2(4), .WDT_W(4), .RETRY_MAX(3)) dut (
      .nub_clk   (nub_clk),
      .nub_reset (nub_reset),
      .bus       (bus.master)
   );

   initial nub_clk = 1'b0;
   always #5 nub_clk = ~nub_clk;

   // observations from the last run_xfer
   logic [31:0] o_ad, o_rdata;
   logic [1:0]  o_tm, o_status;
   logic [4:0]  o_beats;
   int          n_wr, n_rd, n_done, n_start, c_start, c_acko, c_done, data_bad;
   bit          rqst_seen, tb_wvalid;

   task automatic tick();
      @(posedge nub_clk);
      #1;
   endtask

   // Issues one request and plays the slave: beat response every k DATA cycles,
   // n_inter intermediate beats, then a final ack with codes[attempt].
   task automatic run_xfer(input logic [31:0] a, input logic w, input logic [2:0] l,
                           input int n_inter, input int k,
                           input logic [3:0][1:0] codes, input bit no_ack);
      int cyc = 0, wcnt = 0, bi = 0, att = 0;
      bit in_data = 0, fin = 0;
      o_ad = '0; o_rdata = '0; o_tm = '0; o_status = '0; o_beats = '0;
      n_wr = 0; n_rd = 0; n_done = 0; n_start = 0; c_start = -1; c_acko = -1;
      c_done = -1; data_bad = 0; rqst_seen = 0;
      while (!fin && cyc < 300) begin
         bus.req_valid = (cyc == 0);
         bus.req_addr  = a; bus.req_write = w; bus.req_len = l;
         bus.ack_i = 0; bus.tm1_i = 0; bus.tm0_i = 0; bus.ad_i = '0;
         if (in_data && !no_ack) begin
            wcnt++;
            if (wcnt == k) begin
               wcnt = 0;
               bus.ad_i = 32'hD000_0000 + bi;
               if (bi < n_inter) begin
                  bus.tm0_i = 1; bi++;
               end else begin
                  bus.ack_i = 1; {bus.tm1_i, bus.tm0_i} = codes[att]; att++; in_data = 0;
               end
            end
         end
         bus.wdata = 32'hA000_0000 + n_wr;
         bus.wdata_valid = tb_wvalid;
         #1;
         if (bus.rqst_o) rqst_seen = 1;
         if (bus.start_o) begin
            n_start++; o_ad = bus.ad_o; o_tm = {bus.tm1_o, bus.tm0_o};
            c_start = cyc; in_data = 1; wcnt = 0; bi = 0;
         end
         if (bus.wdata_ready) begin
            if (bus.ad_o !== 32'hA000_0000 + n_wr) data_bad++;
            n_wr++;
         end
         if (bus.rdata_valid) begin o_rdata = bus.rdata; n_rd++; end
         if (bus.ack_o) begin c_acko = cyc; in_data = 0; end
         if (bus.done) begin
            n_done++; c_done = cyc; o_status = bus.status; o_beats = bus.beats; fin = 1;
         end
         tick();
         cyc++;
      end
      bus.req_valid = 0; bus.ack_i = 0; bus.tm1_i = 0; bus.tm0_i = 0;
      if (!fin) begin
         checks++; errors++;
         $display("FAIL xfer_timeout addr=%h got no done want done within 300 cycles", a);
      end
   endtask

   task automatic test_reset();
      logic [81:0] outs;
      nub_reset = 1;
      bus.req_valid = 0; bus.req_addr = '0; bus.req_write = 0; bus.req_len = '0;
      bus.wdata = '0; bus.wdata_valid = 0; bus.arb_grant = 1; bus.start_i = 0;
      bus.ack_i = 0; bus.tm1_i = 0; bus.tm0_i = 0; bus.ad_i = '0;
      tick(); tick(); tick();
      outs = {bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.done, bus.status,
              bus.beats, bus.arbcy_o, bus.rqst_o, bus.start_o, bus.ack_o, bus.tm1_o,
              bus.tm0_o, bus.tm_oe, bus.ad_oe, bus.rdata, bus.ad_o};
      checks++; if (outs !== '0) begin errors++; $display("FAIL reset.outputs got %h want 0", outs); end
      nub_reset = 0; #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset.req_ready got %b want 1", bus.req_ready); end
   endtask

   task automatic test_single_read();
      run_xfer(32'hF300_0010, 0, 3'd0, 0, 3, {2'd0, 2'd0, 2'd0, 2'd0}, 0);
      checks++; if (o_ad !== 32'hF300_0010) begin errors++; $display("FAIL single_read.ad got %h want f3000010", o_ad); end
      checks++; if (o_tm !== 2'b00) begin errors++; $display("FAIL single_read.tm got %b want 00", o_tm); end
      checks++; if (n_rd !== 1) begin errors++; $display("FAIL single_read.rvalid got %0d want 1", n_rd); end
      checks++; if (o_rdata !== 32'hD000_0000) begin errors++; $display("FAIL single_read.rdata got %h want d0000000", o_rdata); end
      checks++; if (o_status !== 2'd0 || o_beats !== 5'd1) begin errors++; $display("FAIL single_read.done got st=%0d beats=%0d want st=0 beats=1", o_status, o_beats); end
      checks++; if (c_done - c_start !== 4) begin errors++; $display("FAIL single_read.latency got %0d want 4", c_done - c_start); end
   endtask

   task automatic test_block_write();
      run_xfer(32'hF300_0040, 1, 3'd2, 3, 2, {2'd0, 2'd0, 2'd0, 2'd0}, 0);
      checks++; if (o_ad !== 32'hF300_0048) begin errors++; $display("FAIL block_write.ad got %h want f3000048", o_ad); end
      checks++; if (o_tm !== 2'b11) begin errors++; $display("FAIL block_write.tm got %b want 11", o_tm); end
      checks++; if (n_wr !== 4) begin errors++; $display("FAIL block_write.wready got %0d want 4", n_wr); end
      checks++; if (data_bad !== 0) begin errors++; $display("FAIL block_write.ad_data got %0d bad beats want 0", data_bad); end
      checks++; if (o_status !== 2'd0 || o_beats !== 5'd4) begin errors++; $display("FAIL block_write.done got st=%0d beats=%0d want st=0 beats=4", o_status, o_beats); end
   endtask

   task automatic test_reject();
      run_xfer(32'hF300_0044, 0, 3'd2, 0, 1, {2'd0, 2'd0, 2'd0, 2'd0}, 0);
      checks++; if (c_done !== 1) begin errors++; $display("FAIL misalign.done_cycle got %0d want 1", c_done); end
      checks++; if (o_status !== 2'd1 || o_beats !== 5'd0) begin errors++; $display("FAIL misalign.done got st=%0d beats=%0d want st=1 beats=0", o_status, o_beats); end
      checks++; if (rqst_seen !== 0 || n_start !== 0) begin errors++; $display("FAIL misalign.bus got rqst=%0d starts=%0d want 0 0", rqst_seen, n_start); end
      run_xfer(32'hF300_0000, 0, 3'd5, 0, 1, {2'd0, 2'd0, 2'd0, 2'd0}, 0);
      checks++; if (o_status !== 2'd1 || c_done !== 1) begin errors++; $display("FAIL len_big.done got st=%0d cyc=%0d want st=1 cyc=1", o_status, c_done); end
      checks++; if (rqst_seen !== 0) begin errors++; $display("FAIL len_big.rqst got %0d want 0", rqst_seen); end
   endtask

   task automatic test_try_again();
      run_xfer(32'hF300_0020, 0, 3'd0, 0, 1, {2'd0, 2'd3, 2'd3, 2'd3}, 0);
      checks++; if (n_start !== 4) begin errors++; $display("FAIL retry_ok.starts got %0d want 4", n_start); end
      checks++; if (o_status !== 2'd0 || o_beats !== 5'd1 || n_rd !== 1) begin errors++; $display("FAIL retry_ok.done got st=%0d beats=%0d rd=%0d want 0 1 1", o_status, o_beats, n_rd); end
      run_xfer(32'hF300_0020, 0, 3'd0, 0, 1, {2'd3, 2'd3, 2'd3, 2'd3}, 0);
      checks++; if (n_start !== 4) begin errors++; $display("FAIL retry_exh.starts got %0d want 4", n_start); end
      checks++; if (o_status !== 2'd3 || o_beats !== 5'd0 || n_rd !== 0) begin errors++; $display("FAIL retry_exh.done got st=%0d beats=%0d rd=%0d want 3 0 0", o_status, o_beats, n_rd); end
   endtask

   task automatic test_watchdog();
      run_xfer(32'hF300_0000, 0, 3'd0, 0, 1, {2'd0, 2'd0, 2'd0, 2'd0}, 1);
      checks++; if (c_acko - c_start !== 16) begin errors++; $display("FAIL wdt.ack_o_delay got %0d want 16", c_acko - c_start); end
      checks++; if (o_status !== 2'd2 || o_beats !== 5'd0) begin errors++; $display("FAIL wdt.done got st=%0d beats=%0d want 2 0", o_status, o_beats); end
      checks++; if (c_done - c_acko !== 1) begin errors++; $display("FAIL wdt.done_cycle got %0d want 1", c_done - c_acko); end
   endtask

   task automatic test_early_ack();
      run_xfer(32'hF300_0000, 0, 3'd2, 1, 2, {2'd0, 2'd0, 2'd0, 2'd0}, 0);
      checks++; if (o_status !== 2'd0 || o_beats !== 5'd2) begin errors++; $display("FAIL early_ack.done got st=%0d beats=%0d want 0 2", o_status, o_beats); end
      checks++; if (n_rd !== 2 || o_rdata !== 32'hD000_0001) begin errors++; $display("FAIL early_ack.rdata got n=%0d last=%h want 2 d0000001", n_rd, o_rdata); end
   endtask

   task automatic test_bus_error();
      run_xfer(32'hF300_0000, 0, 3'd0, 0, 2, {2'd0, 2'd0, 2'd0, 2'd1}, 0);
      checks++; if (o_status !== 2'd1 || o_beats !== 5'd0 || n_rd !== 0) begin errors++; $display("FAIL bus_err.done got st=%0d beats=%0d rd=%0d want 1 0 0", o_status, o_beats, n_rd); end
      run_xfer(32'hF300_0000, 0, 3'd0, 0, 2, {2'd0, 2'd0, 2'd0, 2'd2}, 0);
      checks++; if (o_status !== 2'd2 || n_start !== 1) begin errors++; $display("FAIL bus_tmo.done got st=%0d starts=%0d want 2 1", o_status, n_start); end
   endtask

   task automatic test_underrun();
      tb_wvalid = 0;
      run_xfer(32'hF300_0000, 1, 3'd0, 0, 1, {2'd0, 2'd0, 2'd0, 2'd0}, 0);
      tb_wvalid = 1;
      checks++; if (o_status !== 2'd1 || o_beats !== 5'd1) begin errors++; $display("FAIL underrun.done got st=%0d beats=%0d want 1 1", o_status, o_beats); end
   endtask

   task automatic test_reset_mid();
      logic [81:0] outs;
      int nd = 0;
      bus.req_valid = 1; bus.req_addr = 32'hF300_0000; bus.req_write = 0; bus.req_len = 3'd3;
      tick();
      bus.req_valid = 0;
      for (int i = 0; i < 20 && !bus.start_o; i++) tick();
      checks++; if (bus.start_o !== 1'b1) begin errors++; $display("FAIL reset_mid.start got %b want 1", bus.start_o); end
      tick();
      bus.tm0_i = 1; bus.ad_i = 32'h1234_5678; #1;
      checks++; if (bus.rdata_valid !== 1'b1 || bus.rdata !== 32'h1234_5678) begin errors++; $display("FAIL reset_mid.inter got v=%b d=%h want 1 12345678", bus.rdata_valid, bus.rdata); end
      tick();
      bus.tm0_i = 0; bus.ad_i = '0; nub_reset = 1;
      tick();
      outs = {bus.req_ready, bus.wdata_ready, bus.rdata_valid, bus.done, bus.status,
              bus.beats, bus.arbcy_o, bus.rqst_o, bus.start_o, bus.ack_o, bus.tm1_o,
              bus.tm0_o, bus.tm_oe, bus.ad_oe, bus.rdata, bus.ad_o};
      checks++; if (outs !== '0) begin errors++; $display("FAIL reset_mid.outputs got %h want 0", outs); end
      nub_reset = 0;
      for (int i = 0; i < 6; i++) begin
         #1; if (bus.done) nd++;
         tick();
      end
      checks++; if (nd !== 0) begin errors++; $display("FAIL reset_mid.no_done got %0d want 0", nd); end
      run_xfer(32'hF300_0010, 0, 3'd0, 0, 2, {2'd0, 2'd0, 2'd0, 2'd0}, 0);
      checks++; if (n_done !== 1 || o_status !== 2'd0 || o_beats !== 5'd1) begin errors++; $display("FAIL reset_mid.after got n=%0d st=%0d beats=%0d want 1 0 1", n_done, o_status, o_beats); end
   endtask

   initial begin
      tb_wvalid = 1;
      test_reset();
      test_single_read();
      test_block_write();
      test_reject();
      test_try_again();
      test_watchdog();
      test_early_ack();
      test_bus_error();
      test_underrun();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/nubus_block_master.md
Name: nubus_block_master

Overview:
- Next-generation NuBus master transfer engine.
- Generalises the single-word CPU master path to parametrised block transfers of 1–2^MAX_BLOCK_LOG2 words. Adds automatic retry on "try again later", a per-beat watchdog, and streamed read/write data.
- Sits between a CPU/DMA requester and the NuBus pad layer. Uses the existing nubus_arbiter grant.
- Bus-side signals are active-high, with separate out/output-enable pairs; the pad layer inverts them and builds the open-collector drivers.

Parameters:
- MAX_BLOCK_LOG2, 4, largest block is 2^MAX_BLOCK_LOG2 words; legal range 0..4.
- WDT_W, 8, watchdog width; a beat aborts after 2^WDT_W cycles without acknowledge.
- RETRY_MAX, 3, number of re-arbitrations after a try-again status before reporting it.

Ports:
- nub_clk  in  1  NuBus clock, already inverted; all state updates on rising edge.
- nub_reset  in  1  synchronous, active-high reset.
- req_valid  in  1  transfer request.
- req_ready  out  1  high in IDLE only; request accepted when valid&ready.
- req_addr  in  32  word address; bits[1:0] ignored.
- req_write  in  1  1=write, 0=read.
- req_len  in  3  log2 of word count.
- wdata  in  32  write beat data.
- wdata_valid  in  1  write beat available.
- wdata_ready  out  1  one-cycle pulse when a write beat is acknowledged.
- rdata  out  32  read beat data.
- rdata_valid  out  1  one-cycle pulse per acknowledged read beat.
- done  out  1  one-cycle completion pulse.
- status  out  2  valid with done: 0 ok, 1 error, 2 timeout, 3 try-again-exhausted.
- beats  out  5  acknowledged beat count, valid with done.
- arb_grant  in  1  from nubus_arbiter.
- arbcy_o  out  1  enable arbitration contest.
- rqst_o  out  1  assert RQST.
- start_i, ack_i, tm1_i, tm0_i  in  1 each  sampled bus lines, active-high.
- start_o, ack_o  out  1 each  driven START and ACK.
- tm1_o, tm0_o  out  1 each  driven TM lines.
- tm_oe  out  1  TM output enable.
- ad_i  in  32  sampled AD.
- ad_o  out  32  driven AD.
- ad_oe  out  1  AD output enable.

Behaviour:
- Reset: all outputs 0, FSM IDLE, retry counter and beat counter 0. Reset mid-transfer drops bus drives on the next edge and produces no done pulse.
- bus_busy flag: set on start_i, cleared on ack_i; reset 0.
- Request check on accept:
  - Reject when req_len>MAX_BLOCK_LOG2, or when req_addr is not aligned to 2^req_len words.
  - Rejection: done=1, status=1, beats=0 the next cycle, with no bus activity.
- FSM states and transitions:
  - IDLE: on an accepted request, latch addr/write/len and go to ARB.
  - ARB: rqst_o=1, arbcy_o=1. Go to ADDR when arb_grant & ~bus_busy & ~start_i.
  - ADDR: one cycle. start_o=1, ad_oe=1, tm_oe=1. Go to DATA.
  - DATA: rqst_o=0.
  - DONE: one cycle. done=1. Return to IDLE.
- Address cycle encoding:
  - tm1_o=write; tm0_o=(len!=0).
  - ad_o[31:6]=addr[31:6].
  - len=0: ad_o[5:0]={addr[5:2],2'b00}.
  - len=L>0: ad_o[5:2]=4'b0001<<(L-1), ad_o[1:0]=2'b00.
- Data phase drives:
  - Writes: ad_oe=1, ad_o=wdata.
  - Reads: ad_oe=0.
- Write stall: if a write beat is due and wdata_valid=0, the engine still drives stale data and sets an internal underrun flag. The final status is then forced to 1.
- Intermediate beat:
  - Condition: tm0_i=1 & ack_i=0, for a block beat that is not the last.
  - Action: beat counter +1; wdata_ready or rdata_valid pulse (rdata=ad_i); watchdog cleared.
- Final beat (ack_i=1):
  - Latch {tm1_i,tm0_i} as the bus status: 00 ok, 01 error, 10 bus timeout, 11 try-again.
  - Count the beat and pulse its data strobe, but only for ok status.
  - Try-again with retry<RETRY_MAX: retry+1, beat counter and data pointer restart at 0, return to ARB.
  - Try-again otherwise: status 3.
  - Any other status: status equals the bus code.
  - Next state: DONE.
- ACK on the last beat: an early ack_i before the expected final beat terminates the transfer with the status as sampled. beats reports the actual count.
- Watchdog: counts cycles in DATA since the last acknowledge. On terminal count: ack_o=1 for one cycle, status=2, go to DONE.
- Simultaneous ack_i and watchdog expiry: ack_i wins.
- DONE clears retry; done/status/beats are held only for that cycle.

Decomposition:
- Package nubus_pkg:
  - status enum (OK, ERR, TMO, RETRY).
  - FSM state enum.
  - TM code constants.
  - block-size encode function.
- Sub-module nubus_block_wdt: loadable watchdog counter with clear and terminal-count output, WDT_W-parametrised.

Test Plan:
- Single read: addr 0xF3000010, len 0, ack_i with tm=00 at cycle 3 of DATA.
  - Address cycle: ad_o=0xF3000010, tm1_o=0, tm0_o=0.
  - Data: rdata_valid once, done with status 0, beats 1.
- Block write: len 2, addr 0xF3000040, four wdata beats; slave gives 3 tm0 intermediates then ack.
  - Address cycle: ad_o[5:2]=0010, tm0_o=1.
  - Data: 4 wdata_ready pulses, status 0, beats 4.
- Misaligned block: addr 0xF3000044, len 2 → done next cycle, status 1, rqst_o never asserted.
- Try-again: slave returns tm=11 three times, then 00 → 3 re-arbitrations, final status 0. With 4 consecutive try-agains → status 3.
- Watchdog: WDT_W=4, no acknowledge → ack_o pulse 16 cycles after ADDR, status 2.
- Reset asserted in DATA on a len 3 read → next cycle all outputs 0, no done; a following single request completes normally.
